// File: rtl/prio_enc_rr.sv
// prio_enc_rr: N-input priority encoder with a registered, handshaked result.
//
// Two priority modes, selected per accepted request:
//   mode=0  fixed priority, bit 0 highest (lowest set bit wins)
//   mode=1  round-robin, the search starts at a rotating pointer and wraps
//
// Optional feature: define PRIO_ONEHOT_EN to add the grant_oh output, a
// registered one-hot copy of the winning index (all zeros when any=0).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req        request vector, bit i = request i
//   req_valid  req is valid this cycle
//   req_ready  block can accept req this cycle
//   mode       priority mode, sampled on accept
//   out        encoded index of the winning request
//   any        the accepted req had at least one bit set
//   out_valid  out/any hold a result
//   grant_oh   one-hot of the winning index (PRIO_ONEHOT_EN only)
//   out_ready  consumer takes the result this cycle
module prio_enc_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         mode,
  output logic [W-1:0] out,
  output logic         any,
  output logic         out_valid,
`ifdef PRIO_ONEHOT_EN
  output logic [N-1:0] grant_oh,
`endif
  input  logic         out_ready
);

  logic [W-1:0] out_q;
  logic         any_q;
  logic         out_valid_q;
  logic [W-1:0] ptr_q;

  logic         accept;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_hit;
  logic [W-1:0] idx_d;
  logic         any_d;
  logic [W-1:0] ptr_inc;

  // One-entry output register: a new request fits if the slot is empty or
  // is being drained on this same edge.
  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;

  // Fixed priority: scan from the top so the lowest set bit is written last.
  always_comb begin
    fix_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        fix_idx = W'(i);
      end
    end
  end

  // Round-robin: walk N positions starting at ptr_q, wrapping by explicit
  // compare so non-power-of-two N never produces an out-of-range index.
  always_comb begin
    int           pos;
    logic [W-1:0] sel;
    pos    = 0;
    sel    = '0;
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= int'(N)) begin
        pos = pos - int'(N);
      end
      sel = W'(pos);
      if (!rr_hit && req[sel]) begin
        rr_hit = 1'b1;
        rr_idx = sel;
      end
    end
  end

  // With no bit set both searches return 0, which is the required result.
  assign any_d   = |req;
  assign idx_d   = mode ? rr_idx : fix_idx;
  assign ptr_inc = (idx_d == W'(N - 1)) ? '0 : idx_d + W'(1);

`ifdef PRIO_ONEHOT_EN
  logic [N-1:0] oh_q;
  logic [N-1:0] oh_d;

  always_comb begin
    oh_d        = '0;
    oh_d[idx_d] = any_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oh_q <= '0;
    end else if (accept) begin
      oh_q <= oh_d;
    end
  end

  assign grant_oh = oh_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      any_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else if (accept) begin
      out_q       <= idx_d;
      any_q       <= any_d;
      out_valid_q <= 1'b1;
      // Pointer only moves past a real round-robin winner.
      if (mode && any_d) begin
        ptr_q <= ptr_inc;
      end
    end else if (out_ready) begin
      // Consume without a new request: out/any keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign any       = any_q;
  assign out_valid = out_valid_q;

endmodule
